// File: rtl/pattern_packet_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pattern_packet_encoder
//
// Purpose:
//    Serialises one channel configuration into a byte packet for a UART
//    transmitter. The packet layout is:
//       byte0               : {sel_out[3:0], 1'b0, mode, stop, start}
//       next DATA_BIT/8      : output pattern, MSB byte first
//       next DATA_BIT/8      : frequency pattern, MSB byte first
//    Bytes go out one at a time with a start / done-tick handshake.
//
// Optional feature (compile-time macro CHECKSUM_EN):
//    When defined, one extra byte (XOR of all PACK_NUM data bytes) is sent
//    after the last data byte. When undefined, no checksum logic exists.
//
// Ports:
//    clk               system clock
//    rst               asynchronous, active-high reset
//    i_load            one-cycle request to send a packet (sampled in S_IDLE)
//    i_output_pattern  output pattern to encode          [DATA_BIT-1:0]
//    i_freq_pattern    frequency pattern to encode       [DATA_BIT-1:0]
//    i_sel_out         target channel index              [3:0]
//    i_start           channel start bit
//    i_stop            channel stop bit
//    i_mode            channel mode (0 one-shot, 1 repeat)
//    i_tx_done_tick    UART TX pulse: current byte fully shifted out
//    o_tx_data         byte presented to the UART TX     [7:0]
//    o_tx_start        one-cycle pulse: UART TX loads o_tx_data
//    o_busy            high while a packet is in flight
//    o_done_tick       one-cycle pulse: whole packet transmitted
// -----------------------------------------------------------------------------
module pattern_packet_encoder #(
   parameter int DATA_BIT = 32,
   parameter int PACK_NUM = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [DATA_BIT-1:0] i_output_pattern,
   input  logic [DATA_BIT-1:0] i_freq_pattern,
   input  logic [3:0]          i_sel_out,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_mode,
   input  logic                i_tx_done_tick,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_start,
   output logic                o_busy,
   output logic                o_done_tick
);

   localparam int SHIFT_W = PACK_NUM * 8;
   localparam int CNT_W   = $clog2(PACK_NUM + 1);
`ifdef CHECKSUM_EN
   localparam int LAST_IDX = PACK_NUM;
`else
   localparam int LAST_IDX = PACK_NUM - 1;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [SHIFT_W-1:0]   r_shift;
   logic [7:0]           r_tx_data;
   logic                 r_tx_start;
   logic                 r_busy;
   logic                 r_done_tick;

   logic                 w_load_accept;
   logic                 w_advance;
   logic [7:0]           w_ctrl_byte;
   logic [SHIFT_W-1:0]   w_load_word;
   logic [7:0]           w_next_byte;

   assign w_ctrl_byte = {i_sel_out, 1'b0, i_mode, i_stop, i_start};
   assign w_load_word = SHIFT_W'({w_ctrl_byte, i_output_pattern, i_freq_pattern});

`ifdef CHECKSUM_EN
   logic [7:0] r_csum;

   // After the last data byte completes, the checksum is the next byte out.
   assign w_next_byte = (r_cnt == CNT_W'(PACK_NUM - 1)) ? r_csum
                                                        : r_shift[SHIFT_W-9 -: 8];

   // Each data byte is folded in while it is being started; the checksum
   // byte itself (counter == PACK_NUM) is excluded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_csum <= '0;
      end else if (w_load_accept) begin
         r_csum <= '0;
      end else if (r_state == S_SEND && r_cnt < CNT_W'(PACK_NUM)) begin
         r_csum <= r_csum ^ r_tx_data;
      end
   end
`else
   // The byte following the current one sits just below the top byte.
   assign w_next_byte = r_shift[SHIFT_W-9 -: 8];
`endif

   // Next-state logic
   always_comb begin
      w_next_state  = r_state;
      w_load_accept = 1'b0;
      w_advance     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_load) begin
               w_next_state  = S_SEND;
               w_load_accept = 1'b1;
            end
         end
         S_SEND: begin
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (i_tx_done_tick) begin
               if (r_cnt == LAST_CNT) begin
                  w_next_state = S_DONE;
               end else begin
                  w_next_state = S_SEND;
                  w_advance    = 1'b1;
               end
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State, handshake outputs and datapath registers. Outputs are registered
   // from the next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_tx_data   <= '0;
         r_tx_start  <= 1'b0;
         r_busy      <= 1'b0;
         r_done_tick <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_tx_start  <= (w_next_state == S_SEND);
         r_busy      <= (w_next_state != S_IDLE);
         r_done_tick <= (w_next_state == S_DONE);
         if (w_load_accept) begin
            r_shift   <= w_load_word;
            r_cnt     <= '0;
            r_tx_data <= w_ctrl_byte;
         end else if (w_advance) begin
            r_shift   <= r_shift << 8;
            r_cnt     <= r_cnt + 1'b1;
            r_tx_data <= w_next_byte;
         end
      end
   end

   assign o_tx_data   = r_tx_data;
   assign o_tx_start  = r_tx_start;
   assign o_busy      = r_busy;
   assign o_done_tick = r_done_tick;

endmodule

// File: tb/tb_pattern_packet_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pattern_packet_encoder
//
// Scoreboard bench: packets are turned into expected byte lists when loaded;
// a monitor pops and compares every byte the DUT starts, and checks the done
// tick lands one cycle after the final byte's done tick. A UART model answers
// each start with a done tick after a programmable latency.
// -----------------------------------------------------------------------------
module tb_pattern_packet_encoder;

   localparam int DATA_BIT = 32;
   localparam int PACK_NUM = 9;
   localparam int NB       = DATA_BIT / 8;

   logic                clk;
   logic                rst;
   logic                i_load;
   logic [DATA_BIT-1:0] i_output_pattern;
   logic [DATA_BIT-1:0] i_freq_pattern;
   logic [3:0]          i_sel_out;
   logic                i_start;
   logic                i_stop;
   logic                i_mode;
   logic                i_tx_done_tick;
   logic [7:0]          o_tx_data;
   logic                o_tx_start;
   logic                o_busy;
   logic                o_done_tick;

   pattern_packet_encoder #(.DATA_BIT(DATA_BIT), .PACK_NUM(PACK_NUM)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_load           (i_load),
      .i_output_pattern (i_output_pattern),
      .i_freq_pattern   (i_freq_pattern),
      .i_sel_out        (i_sel_out),
      .i_start          (i_start),
      .i_stop           (i_stop),
      .i_mode           (i_mode),
      .i_tx_done_tick   (i_tx_done_tick),
      .o_tx_data        (o_tx_data),
      .o_tx_start       (o_tx_start),
      .o_busy           (o_busy),
      .o_done_tick      (o_done_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   logic [7:0] exp_q[$];
   int         len_q[$];
   int         pkts_expected;
   int         done_seen;
   int         starts_seen;

   // UART model controls
   int lat;
   bit double_tick;
   bit hold_tick;
   int force_req;
   int force_ack;
   int pending;
   bit extra;
   bit tick;

   // monitor state
   int  left;
   bit  await_final;
   bit  expect_done;
   bit  expect_idle;
   logic [7:0] exp_b;
   bit  seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: packet as a list of bytes
   task automatic push_pkt(input logic [DATA_BIT-1:0] o, input logic [DATA_BIT-1:0] f,
                           input logic [3:0] sel, input logic st, input logic sp, input logic md);
      logic [7:0] b;
      logic [7:0] cs;
      int n;
      n  = 0;
      cs = 8'h00;
      b  = 8'(int'(sel) * 16 + int'(md) * 4 + int'(sp) * 2 + int'(st));
      exp_q.push_back(b); cs = cs ^ b; n++;
      for (int k = 0; k < NB; k++) begin
         b = 8'((o >> (8 * (NB - 1 - k))) & 32'hFF);
         exp_q.push_back(b); cs = cs ^ b; n++;
      end
      for (int k = 0; k < NB; k++) begin
         b = 8'((f >> (8 * (NB - 1 - k))) & 32'hFF);
         exp_q.push_back(b); cs = cs ^ b; n++;
      end
`ifdef CHECKSUM_EN
      exp_q.push_back(cs); n++;
`endif
      len_q.push_back(n);
      pkts_expected++;
   endtask

   task automatic set_inputs(input logic [DATA_BIT-1:0] o, input logic [DATA_BIT-1:0] f,
                             input logic [3:0] sel, input logic st, input logic sp, input logic md);
      i_output_pattern = o;
      i_freq_pattern   = f;
      i_sel_out        = sel;
      i_start          = st;
      i_stop           = sp;
      i_mode           = md;
   endtask

   task automatic scramble_inputs();
      i_output_pattern = $urandom;
      i_freq_pattern   = $urandom;
      i_sel_out        = 4'($urandom);
      i_start          = 1'($urandom);
      i_stop           = 1'($urandom);
      i_mode           = 1'($urandom);
   endtask

   // Load a packet while the DUT is idle; start must follow in the next cycle.
   task automatic load_pkt(input logic [DATA_BIT-1:0] o, input logic [DATA_BIT-1:0] f,
                           input logic [3:0] sel, input logic st, input logic sp, input logic md);
      @(posedge clk); #1;
      set_inputs(o, f, sel, st, sp, md);
      i_load = 1'b1;
      push_pkt(o, f, sel, st, sp, md);
      @(posedge clk); #1;
      i_load = 1'b0;
      @(negedge clk);
      check("load_to_start", {31'd0, o_tx_start}, 32'd1);
   endtask

   task automatic load_random();
      load_pkt($urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic wait_done(input bit scramble);
      seen = 1'b0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(posedge clk); #1;
         if (scramble) scramble_inputs();
         @(negedge clk);
         if (o_done_tick) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL wait_done: got no done tick expected one within 3000 cycles");
      end
   endtask

   task automatic wait_starts(input int target);
      for (int n = 0; n < 3000 && starts_seen < target; n++) @(negedge clk);
      if (starts_seen < target) begin
         checks++;
         errors++;
         $display("FAIL wait_starts: got %0d starts expected %0d", starts_seen, target);
      end
   endtask

   int s0;
   int d0;

   initial begin
      checks = 0; errors = 0;
      pkts_expected = 0; done_seen = 0; starts_seen = 0;
      lat = 16; double_tick = 0; hold_tick = 1; force_req = 0; force_ack = 0;
      pending = 0; extra = 0; tick = 0;
      left = 0; await_final = 0; expect_done = 0; expect_idle = 0;
      rst = 1'b1; i_load = 1'b1; i_tx_done_tick = 1'b1;
      set_inputs('0, '0, 4'd0, 1'b0, 1'b0, 1'b0);

      fork
         // UART TX model
         forever begin
            @(posedge clk); #1;
            tick = 1'b0;
            if (rst) begin
               pending = 0;
               extra   = 1'b0;
            end else begin
               if (pending > 0) begin
                  pending--;
                  if (pending == 0) begin
                     tick  = 1'b1;
                     extra = double_tick;
                  end
               end else if (extra) begin
                  tick  = 1'b1;
                  extra = 1'b0;
               end
               if (o_tx_start) pending = lat;
               if (force_req != force_ack) begin
                  tick = 1'b1;
                  force_ack++;
               end
            end
            i_tx_done_tick = tick | hold_tick;
         end
         // Scoreboard monitor
         forever begin
            @(negedge clk);
            if (rst) begin
               left = 0; await_final = 0; expect_done = 0; expect_idle = 0;
            end else begin
               if (expect_idle) begin
                  check("busy_after_done", {31'd0, o_busy}, 32'd0);
                  expect_idle = 0;
               end
               if (o_done_tick) done_seen++;
               if (expect_done) begin
                  check("done_latency", {31'd0, o_done_tick}, 32'd1);
                  expect_done = 0;
                  expect_idle = 1;
               end else if (o_done_tick) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: got 1 expected 0");
               end
               if (await_final && i_tx_done_tick && !o_tx_start) begin
                  expect_done = 1;
                  await_final = 0;
               end
               if (o_tx_start) begin
                  starts_seen++;
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_start: got start with data %0h expected none", o_tx_data);
                  end else begin
                     if (left == 0) left = len_q.pop_front();
                     exp_b = exp_q.pop_front();
                     check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_b});
                     check("busy_during_pkt", {31'd0, o_busy}, 32'd1);
                     left--;
                     if (left == 0) await_final = 1;
                  end
               end
            end
         end
      join_none

      // Reset with load and done tick held high
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
      check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done_tick}, 32'd0);
      @(posedge clk); #1;
      i_load = 1'b0; hold_tick = 0; i_tx_done_tick = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("no_start_after_reset", starts_seen, 0);

      // Basic packet
      lat = 16;
      load_pkt(32'h12345678, 32'h0000_03E8, 4'd2, 1'b1, 1'b0, 1'b1);
      wait_done(0);

      // Spurious done tick while idle
      repeat (3) @(posedge clk);
      force_req++;
      repeat (6) @(negedge clk);
      check("idle_tick_ignored", starts_seen, PACK_NUM + ((len_q.size() == 0 && exp_q.size() == 0) ? (starts_seen - PACK_NUM) : 0));
      check("idle_busy", {31'd0, o_busy}, 32'd0);

      // Double done ticks
      double_tick = 1; lat = 3;
      load_random();
      wait_done(0);
      double_tick = 0;

      // Load while busy, then held reload accepted right after done
      lat = 6;
      s0 = starts_seen;
      load_random();
      wait_starts(s0 + 4);
      @(posedge clk); #1;
      scramble_inputs();
      i_load = 1'b1;
      @(posedge clk); #1;
      set_inputs(32'hCAFE_F00D, 32'hA5A5_0101, 4'd9, 1'b0, 1'b1, 1'b0);
      push_pkt(32'hCAFE_F00D, 32'hA5A5_0101, 4'd9, 1'b0, 1'b1, 1'b0);
      wait_done(0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_load = 1'b0;
      @(negedge clk);
      check("reload_after_done", {31'd0, o_tx_start}, 32'd1);
      wait_done(0);

      // Inputs change every cycle after load
      lat = 2;
      load_random();
      wait_done(1);

      // Random packets with random UART latency
      for (int p = 0; p < 6; p++) begin
         lat = $urandom_range(1, 5);
         double_tick = 1'($urandom);
         load_random();
         wait_done(p[0]);
      end
      double_tick = 0;

      // Reset mid-packet
      lat = 4;
      s0 = starts_seen;
      load_random();
      wait_starts(s0 + 3);
      @(posedge clk); #1;
      rst = 1'b1; i_load = 1'b1; hold_tick = 1;
      @(negedge clk);
      check("midrst_tx_data", {24'd0, o_tx_data}, 32'd0);
      check("midrst_tx_start", {31'd0, o_tx_start}, 32'd0);
      check("midrst_busy", {31'd0, o_busy}, 32'd0);
      check("midrst_done", {31'd0, o_done_tick}, 32'd0);
      exp_q.delete();
      len_q.delete();
      pkts_expected--;
      @(posedge clk); #1;
      i_load = 1'b0; hold_tick = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      s0 = starts_seen;
      d0 = done_seen;
      repeat (20) @(negedge clk);
      check("midrst_no_start", starts_seen, s0);
      check("midrst_no_done", done_seen, d0);

      // Recovery packet
      load_random();
      wait_done(0);

      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      check("done_count", done_seen, pkts_expected);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
